// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose: lock-state encoding, requester count and port index type used by
//          dmem_arbiter and dmem_arb_select.
// Contents:
//   lock_state_t  LOCK_NONE / LOCK_OWN0 / LOCK_OWN1
//   NUM_REQ       number of requesters (2)
//   port_idx_t    index of a requester port
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_OWN0 = 2'd1,
    LOCK_OWN1 = 2'd2
  } lock_state_t;

  typedef logic port_idx_t;

endpackage

// File: rtl/dmem_arb_select.sv
// rtl/dmem_arb_select.sv - combinational winner selection for the data-memory arbiter
//
// Purpose: picks at most one requester to grant this cycle from the requests,
//          the effective lock state and the tie-break pointer.
// Ports:
//   i_rst         reset active; forces no grant
//   i_req         per-port request
//   i_lock_state  effective lock state (already released if the owner let go)
//   i_rr_ptr      port that wins a tie when unlocked
//   o_gnt         one-hot (or zero) grant vector
module dmem_arb_select
  import dmem_arb_pkg::*;
(
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  lock_state_t        i_lock_state,
  input  port_idx_t          i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (!i_rst) begin
      unique case (i_lock_state)
        LOCK_OWN0: o_gnt[0] = i_req[0];
        LOCK_OWN1: o_gnt[1] = i_req[1];
        default: begin
          if (&i_req) begin
            o_gnt[i_rr_ptr] = 1'b1;
          end else begin
            // zero or one requester: it is already the one-hot answer
            o_gnt = i_req;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the shared data-memory port
//
// Purpose: shares the memory data port between the processor (port 0) and a
//          debug/loader master (port 1); one access per cycle, lock support for
//          atomic sequences, read data steered back one cycle after the grant.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking when
//          unlocked; otherwise port 0 always wins ties.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rN_req/we/lock/addr/wdata      requester N access
//   rN_gnt                         access accepted this cycle (combinational)
//   rN_rvalid, rN_rdata            read response, one cycle after the grant
//   mem_addr/we/wdata              memory data port request
//   mem_rdata                      memory read data (1-cycle latency)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lock_state_t        r_lock_state;
  lock_state_t        w_eff_state;
  lock_state_t        w_lock_next;
  logic               r_resp_valid;
  port_idx_t          r_resp_sel;
  port_idx_t          w_rr_ptr;
  port_idx_t          w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;

  // An owner that neither requests nor holds lock releases immediately, so
  // the other port can be served in that same cycle.
  always_comb begin
    w_eff_state = r_lock_state;
    if (r_lock_state == LOCK_OWN0 && !r0_req && !r0_lock) w_eff_state = LOCK_NONE;
    if (r_lock_state == LOCK_OWN1 && !r1_req && !r1_lock) w_eff_state = LOCK_NONE;
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  port_idx_t r_rr_ptr;

  // After every grant the other port gets the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (|w_gnt) begin
      r_rr_ptr <= ~w_gnt_idx;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = 1'b0;
`endif

  dmem_arb_select u_select (
    .i_rst        (rst),
    .i_req        ({r1_req, r0_req}),
    .i_lock_state (w_eff_state),
    .i_rr_ptr     (w_rr_ptr),
    .o_gnt        (w_gnt)
  );

  assign r0_gnt = w_gnt[0];
  assign r1_gnt = w_gnt[1];

  // Memory port mux; idles at zero when nobody is granted.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    w_gnt_idx = 1'b0;
    if (w_gnt[0]) begin
      mem_addr  = r0_addr;
      mem_we    = r0_we;
      mem_wdata = r0_wdata;
    end else if (w_gnt[1]) begin
      mem_addr  = r1_addr;
      mem_we    = r1_we;
      mem_wdata = r1_wdata;
      w_gnt_idx = 1'b1;
    end
  end

  // The granted access decides the lock; with no grant the effective state
  // (held or just released) carries over.
  always_comb begin
    w_lock_next = w_eff_state;
    if (w_gnt[0]) begin
      w_lock_next = r0_lock ? LOCK_OWN0 : LOCK_NONE;
    end else if (w_gnt[1]) begin
      w_lock_next = r1_lock ? LOCK_OWN1 : LOCK_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= LOCK_NONE;
      r_resp_valid <= 1'b0;
      r_resp_sel   <= 1'b0;
    end else begin
      r_lock_state <= w_lock_next;
      r_resp_valid <= (|w_gnt) && !mem_we;
      if (|w_gnt) r_resp_sel <= w_gnt_idx;
    end
  end

  // Gating with rst drops a response whose data cycle coincides with reset.
  assign r0_rvalid = r_resp_valid && (r_resp_sel == 1'b0) && !rst;
  assign r1_rvalid = r_resp_valid && (r_resp_sel == 1'b1) && !rst;

  assign r0_rdata = mem_rdata;
  assign r1_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h0080_0000;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous memory: write at the grant edge, read data one cycle later.
  logic [31:0] tb_mem [0:255];
  always @(posedge clk) begin
    mem_rdata <= tb_mem[mem_addr[9:2]];
    if (mem_we) tb_mem[mem_addr[9:2]] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        q0, w0, l0;
    logic [31:0] a0, d0;
    logic        q1, w1, l1;
    logic [31:0] a1, d1;
    logic        g0, g1, rv0, rv1;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst_i,
                             input logic q0, input logic w0, input logic l0,
                             input logic [31:0] a0, input logic [31:0] d0,
                             input logic q1, input logic w1, input logic l1,
                             input logic [31:0] a1, input logic [31:0] d1,
                             input logic g0, input logic g1,
                             input logic rv0, input logic rv1, input logic [31:0] rd);
    vec_t t;
    t.rst = rst_i;
    t.q0 = q0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.d0 = d0;
    t.q1 = q1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.rv0 = rv0; t.rv1 = rv1; t.rd = rd;
    return t;
  endfunction

  // reference model state for the random phase
  logic [31:0] model_mem [0:255];
  int          owner, fav, eff, win, pend_port;
  bit          pend;
  logic [31:0] pend_data;
  bit          rq[2], rw[2], rl[2];
  logic [31:0] ra[2], rd[2];

  initial begin
    logic [31:0] A4, A5, A8, AC, A9, DB, F5, K1, K2, K3;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd;
    A4 = BASE + 32'h10; A5 = BASE + 32'h14; A8 = BASE + 32'h20;
    AC = BASE + 32'h30; A9 = BASE + 32'h24;
    DB = 32'hDEADBEEF; F5 = 32'h55555555;
    K1 = 32'h12345678; K2 = 32'hA5A5A5A5; K3 = 32'hCAFEF00D;

    for (int i = 0; i < 256; i++) tb_mem[i] = (i * 32'h01010101) ^ 32'h0000005A;
    tb_mem[4] = DB;
    tb_mem[5] = F5;

    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;

    //                rst q0 w0 l0 a0  d0   q1 w1 l1 a1  d1   g0      g1      rv0     rv1     rd
    vecs.push_back(v(1, 1, 0, 0, A4, 0,   0, 0, 0, 0,  0,   0,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   0, 0, 0, 0,  0,   1,      0,      0,      0,      0));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      1,      0,      DB));
    vecs.push_back(v(1, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   1, 0, 0, A5, 0,   1,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   1, 0, 0, A5, 0,   !RR,    RR,     1,      0,      DB));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   1, 0, 0, A5, 0,   1,      0,      !RR,    RR,     RR ? F5 : DB));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   1, 0, 0, A5, 0,   !RR,    RR,     1,      0,      DB));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      !RR,    RR,     RR ? F5 : DB));
    // r1 locked write then unlocked read while r0 waits
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   1, 1, 1, A8, K1,  0,      1,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   1, 0, 0, A8, 0,   0,      1,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, A4, 0,   0, 0, 0, 0,  0,   1,      0,      0,      1,      K1));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      1,      0,      DB));
    // r1 holds lock without requesting, then releases
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   1, 0, 1, A8, 0,   0,      1,      0,      0,      0));
    vecs.push_back(v(0, 1, 1, 0, AC, K2,  0, 0, 1, 0,  0,   0,      0,      0,      1,      K1));
    vecs.push_back(v(0, 1, 1, 0, AC, K2,  0, 0, 1, 0,  0,   0,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 1, 0, AC, K2,  0, 0, 1, 0,  0,   0,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 1, 0, AC, K2,  0, 0, 0, 0,  0,   1,      0,      0,      0,      0));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      0,      0,      0));
    // reset during OWN1 with a read outstanding
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   1, 0, 1, A8, 0,   0,      1,      0,      0,      0));
    vecs.push_back(v(1, 1, 0, 0, AC, 0,   0, 0, 1, 0,  0,   0,      0,      0,      0,      0));
    vecs.push_back(v(0, 1, 0, 0, AC, 0,   0, 0, 1, 0,  0,   1,      0,      0,      0,      0));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      1,      0,      K2));
    // write by r0 then read of the same word by r1
    vecs.push_back(v(0, 1, 1, 0, A9, K3,  0, 0, 0, 0,  0,   1,      0,      0,      0,      0));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   1, 0, 0, A9, 0,   0,      1,      0,      0,      0));
    vecs.push_back(v(0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0,      0,      0,      1,      K3));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      r0_req = vecs[i].q0; r0_we = vecs[i].w0; r0_lock = vecs[i].l0;
      r0_addr = vecs[i].a0; r0_wdata = vecs[i].d0;
      r1_req = vecs[i].q1; r1_we = vecs[i].w1; r1_lock = vecs[i].l1;
      r1_addr = vecs[i].a1; r1_wdata = vecs[i].d1;
      exp_we   = vecs[i].g0 ? vecs[i].w0 : (vecs[i].g1 ? vecs[i].w1 : 1'b0);
      exp_addr = vecs[i].g0 ? vecs[i].a0 : (vecs[i].g1 ? vecs[i].a1 : 32'h0);
      exp_wd   = vecs[i].g0 ? vecs[i].d0 : (vecs[i].g1 ? vecs[i].d1 : 32'h0);
      @(negedge clk);
      chk($sformatf("row%0d r0_gnt", i), {31'b0, r0_gnt}, {31'b0, vecs[i].g0});
      chk($sformatf("row%0d r1_gnt", i), {31'b0, r1_gnt}, {31'b0, vecs[i].g1});
      chk($sformatf("row%0d mem_we", i), {31'b0, mem_we}, {31'b0, exp_we});
      chk($sformatf("row%0d mem_addr", i), mem_addr, exp_addr);
      if (exp_we) chk($sformatf("row%0d mem_wdata", i), mem_wdata, exp_wd);
      chk($sformatf("row%0d r0_rvalid", i), {31'b0, r0_rvalid}, {31'b0, vecs[i].rv0});
      chk($sformatf("row%0d r1_rvalid", i), {31'b0, r1_rvalid}, {31'b0, vecs[i].rv1});
      if (vecs[i].rv0) chk($sformatf("row%0d r0_rdata", i), r0_rdata, vecs[i].rd);
      if (vecs[i].rv1) chk($sformatf("row%0d r1_rdata", i), r1_rdata, vecs[i].rd);
    end

    // random phase against the behavioural model
    for (int i = 0; i < 256; i++) model_mem[i] = tb_mem[i];
    owner = -1; fav = 0; pend = 0; pend_port = 0; pend_data = 0;

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      rst = (c == 0) || ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++) begin
        rq[p] = ($urandom_range(0, 9) < 7);
        rw[p] = $urandom_range(0, 1) == 1;
        rl[p] = ($urandom_range(0, 3) == 0);
        ra[p] = BASE | (32'($urandom_range(0, 15)) << 2);
        rd[p] = $urandom;
      end
      r0_req = rq[0]; r0_we = rw[0]; r0_lock = rl[0]; r0_addr = ra[0]; r0_wdata = rd[0];
      r1_req = rq[1]; r1_we = rw[1]; r1_lock = rl[1]; r1_addr = ra[1]; r1_wdata = rd[1];

      eff = owner;
      if (owner >= 0 && !rq[owner] && !rl[owner]) eff = -1;
      win = -1;
      if (!rst) begin
        if (eff >= 0) begin
          if (rq[eff]) win = eff;
        end else if (rq[0] && rq[1]) begin
          win = RR ? fav : 0;
        end else if (rq[0]) begin
          win = 0;
        end else if (rq[1]) begin
          win = 1;
        end
      end

      @(negedge clk);
      chk($sformatf("rnd%0d r0_gnt", c), {31'b0, r0_gnt}, {31'b0, win == 0});
      chk($sformatf("rnd%0d r1_gnt", c), {31'b0, r1_gnt}, {31'b0, win == 1});
      chk($sformatf("rnd%0d mem_we", c), {31'b0, mem_we}, {31'b0, (win >= 0) && rw[win]});
      chk($sformatf("rnd%0d mem_addr", c), mem_addr, (win >= 0) ? ra[win] : 32'h0);
      if (win >= 0 && rw[win]) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, rd[win]);
      chk($sformatf("rnd%0d r0_rvalid", c), {31'b0, r0_rvalid}, {31'b0, pend && !rst && pend_port == 0});
      chk($sformatf("rnd%0d r1_rvalid", c), {31'b0, r1_rvalid}, {31'b0, pend && !rst && pend_port == 1});
      if (pend && !rst) begin
        if (pend_port == 0) chk($sformatf("rnd%0d r0_rdata", c), r0_rdata, pend_data);
        else                chk($sformatf("rnd%0d r1_rdata", c), r1_rdata, pend_data);
      end

      if (rst) begin
        owner = -1; fav = 0; pend = 0;
      end else begin
        owner = eff;
        pend  = 0;
        if (win >= 0) begin
          owner     = rl[win] ? win : -1;
          fav       = 1 - win;
          pend      = !rw[win];
          pend_port = win;
          pend_data = model_mem[ra[win][9:2]];
          if (rw[win]) model_mem[ra[win][9:2]] = rd[win];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data port of the processor's instruction/data memory between the processor data path (requester 0) and a debug/loader master (requester 1). Sits directly in front of the memory's data port (address, write enable, write data, synchronous read data). It grants one access per cycle, supports a lock for atomic read-modify-write sequences, and routes the one-cycle-late read data back to the requester that issued the read.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width of requesters and memory port.
- `DATA_WIDTH`, default 32: data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `r0_req`, `r1_req`  in  1  access request, held until granted.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_lock`, `r1_lock`  in  1  keep ownership after this access.
- `r0_addr`, `r1_addr`  in  ADDR_WIDTH  byte address.
- `r0_wdata`, `r1_wdata`  in  DATA_WIDTH  write data.
- `r0_gnt`, `r1_gnt`  out  1  access accepted this cycle (combinational).
- `r0_rvalid`, `r1_rvalid`  out  1  read data valid (registered select).
- `r0_rdata`, `r1_rdata`  out  DATA_WIDTH  read data.
- `mem_addr`  out  ADDR_WIDTH  to memory data address.
- `mem_we`  out  1  to memory write enable.
- `mem_wdata`  out  DATA_WIDTH  to memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid 1 cycle after address.

## Operation
- At most one of `r0_gnt`/`r1_gnt` is high per cycle. A grant is only given to a requesting port.
- Granted port's addr/we/wdata drive `mem_*`. With no grant: `mem_we` = 0 and `mem_addr`/`mem_wdata` = 0.
- Lock state: NONE, OWN0, OWN1. In OWNn only port n can be granted; the other port waits.
  - NONE -> OWNn when port n is granted with `rn_lock` = 1.
  - OWNn -> NONE when port n is granted with `rn_lock` = 0 (that access is still exclusive), or when `rn_req` = 0 and `rn_lock` = 0.
  - OWNn with `rn_req` = 0 and `rn_lock` = 1: no grant, lock held (the memory idles).
- Selection in NONE when both ports request is governed by the Configuration section.
- Read response: a granted read sets `resp_valid` and `resp_sel` (the owning port) at the next edge. A write sets `resp_valid` to 0.
- `rn_rvalid` = `resp_valid` and (`resp_sel` == n). Both `rn_rdata` outputs = `mem_rdata` (unqualified); consumers qualify with rvalid.
- Reset values: lock state NONE, `resp_valid` 0, `r0_rvalid`/`r1_rvalid` 0, round-robin pointer favours port 0. Grants and `mem_we` are 0 whenever `rst` is high, regardless of requests.
- Reset during a locked sequence releases the lock. Reset in the cycle after a read suppresses that read's rvalid.

## Timing
- Grant latency 0: same cycle as request when the port wins.
- Read data latency 1: `rn_rvalid` is high in the cycle after the grant.
- Throughput: one access per cycle. Back-to-back reads from alternating ports produce alternating rvalids with no bubble.
- Memory write takes effect at the grant-cycle edge. A read of the same address in the next cycle returns the new data.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration in NONE.
  - The pointer flips to the other port after every grant.
  - With both ports requesting, grants alternate 0,1,0,1.
- Not defined: fixed priority; port 0 (processor) always wins ties, and port 1 is granted only when `r0_req` = 0.

## Structure
- Shared package `dmem_arb_pkg`:
  - lock-state enum `lock_state_t` {`LOCK_NONE`, `LOCK_OWN0`, `LOCK_OWN1`};
  - `NUM_REQ` = 2;
  - port index type.
- One sub-module, `dmem_arb_select`: purely combinational winner selection from requests, lock state and round-robin pointer. The pointer, lock state and response registers live in `dmem_arb_select`'s parent, `dmem_arbiter`.

## Test plan
- Reset then r0 read addr 0x00800010 (memory returns 0xDEADBEEF): `r0_gnt` same cycle; next cycle `r0_rvalid` = 1, `r0_rdata` = 0xDEADBEEF, `r1_rvalid` = 0.
- Both request reads for 4 cycles, macro defined: grants 0,1,0,1 and rvalids follow one cycle later. Without the macro: r0 granted all 4 cycles, r1 starved.
- r1 write 0x00800020 = 0x12345678 with lock = 1, while r0 requests continuously; then r1 reads 0x00800020 with lock = 0: r0 gets no grant during both r1 accesses; the read returns 0x12345678; r0 is granted in the following cycle.
- r1 holds lock with `r1_req` = 0 for 3 cycles while r0 requests: no grants and `mem_we` = 0. r1 drops lock: r0 is granted that same cycle.
- `rst` asserted during OWN1 with a read outstanding: next cycle no rvalid and lock NONE; r0 is granted on its first request after reset.
- Write then read the same address in consecutive cycles from different ports: the read returns the written value; no rvalid is generated for the write.
